fnd_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 4-digit common-anode FND on the watch/timer board.
- Sits directly upstream of the BCD-to-segment decoder. Each scan slot it selects one digit, drives its nibble on bcd, and drives the active-low digit-common lines.
- Per-digit blinking (edit-mode cursor) and global blanking are applied here. The decoder stays purely combinational.

---
 rtl/fnd_scan_ctrl_pkg.sv | 14 +
 rtl/fnd_scan_ctrl_tick_gen.sv | 29 ++
 rtl/fnd_scan_ctrl.sv | 93 +++++++++
 tb/tb_fnd_scan_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared constants and helpers for the FND scan controller.
// The encodings here must match the downstream BCD-to-segment decoder.
package fnd_pkg;

  localparam int         FND_DIGITS  = 4;
  localparam logic [3:0] FND_COM_OFF = 4'hF;
  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam logic [3:0] BCD_DOT     = 4'd10;

  function automatic int div_ceil(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_tick_gen.sv
// Modulo-MOD counter that emits a one-clock wrap pulse on its final enabled count.
// i_clr restarts the count from zero and takes priority over i_en.
module tick_gen #(
  parameter int MOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);

  localparam int         W    = (MOD > 1) ? $clog2(MOD) : 1;
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_wrap = i_en && (r_cnt == LAST);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for the 4-digit common-anode FND.
// Selects one digit per slot, applies blink/blank, and blanks one clock per slot against ghosting.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic        blank,
  input  logic        blink_sync,
  output logic [3:0]  bcd,
  output logic [3:0]  fnd_com,
  output logic        blink_on
);

  localparam int SCAN_DIV    = CLK_HZ / SCAN_HZ;
  localparam int BLINK_TICKS = div_ceil(SCAN_HZ, 2 * BLINK_HZ);

  logic       w_scan_tick;
  logic       w_blink_wrap;
  logic       w_visible;
  logic [3:0] w_com_nxt;
  logic [3:0] w_bcd_nxt;

  logic [1:0] r_sel;
  logic       r_blink_on;
  logic [3:0] r_com;
  logic [3:0] r_bcd;

  tick_gen #(.MOD(SCAN_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .i_en   (1'b1),
    .i_clr  (1'b0),
    .o_wrap (w_scan_tick)
  );

  tick_gen #(.MOD(BLINK_TICKS)) u_blink_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_scan_tick),
    .i_clr  (blink_sync),
    .o_wrap (w_blink_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= 2'd0;
    end else if (w_scan_tick) begin
      r_sel <= r_sel + 2'd1;
    end
  end

  // A sync pulse wins over a toggle landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst || blink_sync) begin
      r_blink_on <= 1'b1;
    end else if (w_blink_wrap) begin
      r_blink_on <= ~r_blink_on;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_com_nxt = FND_COM_OFF;
    w_bcd_nxt = BCD_BLANK;
    w_visible = !blank && !(blink_mask[r_sel] && !r_blink_on);
    if (!w_scan_tick && w_visible) begin
      w_com_nxt = ~(4'b0001 << r_sel);
      w_bcd_nxt = digits[{r_sel, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_com <= FND_COM_OFF;
      r_bcd <= BCD_BLANK;
    end else begin
      r_com <= w_com_nxt;
      r_bcd <= w_bcd_nxt;
    end
  end

  assign fnd_com  = r_com;
  assign bcd      = r_bcd;
  assign blink_on = r_blink_on;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Randomised and directed bench for fnd_scan_ctrl against a cycle-count reference model.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic        blank;
  logic        blink_sync;
  logic [3:0]  bcd;
  logic [3:0]  fnd_com;
  logic        blink_on;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: clocks since reset, and scan ticks since the last reset/sync.
  int m_cyc   = 0;
  int m_ticks = 0;

  fnd_scan_ctrl #(.CLK_HZ(40), .SCAN_HZ(10), .BLINK_HZ(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .blink_mask (blink_mask),
    .blank      (blank),
    .blink_sync (blink_sync),
    .bcd        (bcd),
    .fnd_com    (fnd_com),
    .blink_on   (blink_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict the registered outputs from pre-edge state, then compare after the edge.
  task automatic step();
    logic [3:0] e_com;
    logic [3:0] e_bcd;
    logic       e_on;
    int         sel;
    bit         tick;
    bit         bon;
    bit         vis;
    e_com = 4'hF;
    e_bcd = 4'hF;
    if (rst) begin
      m_cyc   = 0;
      m_ticks = 0;
    end else begin
      tick = (m_cyc % 4) == 3;
      sel  = (m_cyc / 4) % 4;
      bon  = ((m_ticks / 5) % 2) == 0;
      vis  = !blank && !(blink_mask[sel] && !bon);
      if (!tick && vis) begin
        e_com = ~(4'(1 << sel));
        e_bcd = digits[sel*4 +: 4];
      end
      m_cyc++;
      if (blink_sync)  m_ticks = 0;
      else if (tick)   m_ticks++;
    end
    e_on = ((m_ticks / 5) % 2) == 0;
    @(posedge clk);
    #1;
    blink_sync = 1'b0;
    check("fnd_com", 16'(fnd_com), 16'(e_com));
    check("bcd", 16'(bcd), 16'(e_bcd));
    check("blink_on", 16'(blink_on), 16'(e_on));
    check("one_cold", 16'($countones(~fnd_com) <= 1), 16'd1);
  endtask

  initial begin
    bit found;
    rst = 1'b1; digits = '0; blink_mask = '0; blank = 1'b0; blink_sync = 1'b0;
    step();
    step();
    check("reset_com", 16'(fnd_com), 16'hF);
    check("reset_bcd", 16'(bcd), 16'hF);

    rst = 1'b0;
    digits = 16'h1234;
    step();
    check("first_com", 16'(fnd_com), 16'b1110);
    check("first_bcd", 16'(bcd), 16'd4);
    repeat (32) step();

    blink_mask = 4'b0010;
    repeat (160) step();

    // Sync while blink is off and a toggle is due on the same edge.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((m_cyc % 4) == 3 && (m_ticks % 5) == 4 && ((m_ticks / 5) % 2) == 1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) check("sync_wait_timeout", 16'd0, 16'd1);
    else begin
      check("sync_pre_off", 16'(blink_on), 16'd0);
      blink_sync = 1'b1;
      step();
      check("sync_on", 16'(blink_on), 16'd1);
      repeat (19) begin
        step();
        check("sync_hold", 16'(blink_on), 16'd1);
      end
      step();
      check("sync_toggle", 16'(blink_on), 16'd0);
    end

    blink_mask = 4'b0000;
    repeat (2) step();
    blank = 1'b1;
    repeat (10) begin
      step();
      check("blank_com", 16'(fnd_com), 16'hF);
    end
    blank = 1'b0;
    repeat (20) step();

    // Reset mid-slot while digit2 is selected.
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (((m_cyc / 4) % 4) == 2 && (m_cyc % 4) == 1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) check("sel2_wait_timeout", 16'd0, 16'd1);
    rst = 1'b1;
    step();
    check("midrst_com", 16'(fnd_com), 16'hF);
    check("midrst_on", 16'(blink_on), 16'd1);
    rst = 1'b0;
    digits = 16'hA0F9;
    step();
    check("a0f9_first", 16'(bcd), 16'd9);
    repeat (16) step();

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(49) == 0)  digits = 16'($urandom);
      if ($urandom_range(99) == 0)  blink_mask = 4'($urandom);
      blank      = ($urandom_range(99) < 3);
      blink_sync = ($urandom_range(96) == 0);
      rst        = ($urandom_range(499) == 0);
      step();
    end
    rst = 1'b0;
    blink_sync = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
